// File: rtl/gayle_pkg.sv
// Shared types and constants for the Gayle IDE data-transfer controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package gayle_pkg;

    // Transfer sequencer states
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_HPS_XFER = 2'd1,
        ST_CPU_XFER = 2'd2,
        ST_DONE     = 2'd3
    } xfer_state_t;

    // Default 16-bit words per sector
    localparam int GAYLE_SECTOR_WORDS = 256;

    // Largest sector count a single command can request (count byte 0)
    localparam int GAYLE_MAX_SECTORS = 256;

    // Map the 8-bit task-file sector count onto 1..256; zero means the maximum
    function automatic logic [8:0] count_to_sectors(input logic [7:0] cnt);
        logic [8:0] sectors;
        if (cnt == 8'd0) begin
            sectors = 9'(GAYLE_MAX_SECTORS);
        end else begin
            sectors = {1'b0, cnt};
        end
        return sectors;
    endfunction

endpackage

// File: rtl/gayle_xfer_cnt.sv
// Word-within-sector counter with terminal-count flag for the transfer controller.
// Latency: tc is combinational from the count register; count updates on the next clock.
// Backpressure: none; inc is only raised by the parent on an accepted beat.
module gayle_xfer_cnt
    import gayle_pkg::*;
#(
    parameter int SECTOR_WORDS = GAYLE_SECTOR_WORDS
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic tc
);

    localparam int W = (SECTOR_WORDS > 1) ? $clog2(SECTOR_WORDS) : 1;
    localparam logic [W-1:0] LAST = W'(SECTOR_WORDS - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Terminal count: the beat arriving now is the last word of the sector
    assign tc = (cnt_q == LAST);

    // Clear wins over increment; the terminal beat wraps back to zero
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            if (tc) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Count register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/gayle_xfer_ctrl.sv
// Sequences sector transfers between the CPU data register and the HPS through a shared FIFO.
// Latency: FIFO strobes are zero-latency copies of accepted beats; state/status outputs are registered (1 clock).
// Backpressure: drq / hps_req grant one side at a time; strobes from the side not granted are dropped.
// Optional build macro GAYLE_XFER_IRQ_EN adds the per-sector irq pulse; otherwise irq is tied low.
module gayle_xfer_ctrl
    import gayle_pkg::*;
#(
    parameter int SECTOR_WORDS = GAYLE_SECTOR_WORDS
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clk7_en,
    input  logic       cmd_start,
    input  logic       cmd_dir,
    input  logic [7:0] cmd_count,
    input  logic       abort,
    input  logic       cpu_rd,
    input  logic       cpu_wr,
    input  logic       hps_rd,
    input  logic       hps_wr,
    output logic       fifo_rd,
    output logic       fifo_wr,
    output logic       fifo_fast_rd,
    output logic       fifo_fast_wr,
    output logic       fifo_flush,
    output logic       drq,
    output logic       hps_req,
    output logic       busy,
    output logic       done,
    output logic       irq,
    output logic [8:0] sectors_left
);

    xfer_state_t state_q, state_d;
    logic        dir_q, dir_d;
    logic [8:0]  sl_q, sl_d;
    logic        drq_q, drq_d;
    logic        hps_req_q, hps_req_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        flush_q, flush_d;

    logic        cpu_beat;
    logic        hps_beat;
    logic        any_beat;
    logic        cnt_clr;
    logic        cnt_tc;
    logic        sector_end;
    logic        last_sector;

    // Accepted beats: only the granted side, in the latched direction, and never during abort
    always_comb begin
        cpu_beat = (state_q == ST_CPU_XFER) & clk7_en & (dir_q ? cpu_rd : cpu_wr) & ~abort;
        hps_beat = (state_q == ST_HPS_XFER) & (dir_q ? hps_wr : hps_rd) & ~abort;
    end

    assign any_beat     = cpu_beat | hps_beat;
    assign sector_end   = any_beat & cnt_tc;
    assign last_sector  = (sl_q == 9'd1);

    // Disk read: HPS fills via fast_wr, CPU drains via rd. Disk write: CPU fills via wr, HPS drains via fast_rd.
    assign fifo_rd      = cpu_beat & dir_q;
    assign fifo_wr      = cpu_beat & ~dir_q;
    assign fifo_fast_wr = hps_beat & dir_q;
    assign fifo_fast_rd = hps_beat & ~dir_q;

    gayle_xfer_cnt #(
        .SECTOR_WORDS (SECTOR_WORDS)
    ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (any_beat),
        .clr   (cnt_clr),
        .tc    (cnt_tc)
    );

    // Next-state logic; abort overrides every other event including a start or a final beat
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        sl_d    = sl_q;
        cnt_clr = 1'b0;
        flush_d = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
            sl_d    = 9'd0;
            cnt_clr = 1'b1;
            flush_d = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_start) begin
                        dir_d   = cmd_dir;
                        sl_d    = count_to_sectors(cmd_count);
                        cnt_clr = 1'b1;
                        state_d = cmd_dir ? ST_HPS_XFER : ST_CPU_XFER;
                    end
                end
                ST_HPS_XFER: begin
                    if (sector_end) begin
                        if (dir_q) begin
                            // HPS has filled a sector; hand it to the CPU
                            state_d = ST_CPU_XFER;
                        end else if (last_sector) begin
                            state_d = ST_DONE;
                        end else begin
                            // HPS drained a sector; CPU fills the next one
                            state_d = ST_CPU_XFER;
                            sl_d    = sl_q - 9'd1;
                        end
                    end
                end
                ST_CPU_XFER: begin
                    if (sector_end) begin
                        if (!dir_q) begin
                            // CPU has filled a sector; HPS writes it to disk
                            state_d = ST_HPS_XFER;
                        end else if (last_sector) begin
                            state_d = ST_DONE;
                        end else begin
                            // CPU drained a sector; HPS fetches the next one
                            state_d = ST_HPS_XFER;
                            sl_d    = sl_q - 9'd1;
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Status outputs are decodes of the next state so they appear registered alongside it
    always_comb begin
        drq_d     = (state_d == ST_CPU_XFER);
        hps_req_d = (state_d == ST_HPS_XFER);
        busy_d    = (state_d != ST_IDLE);
        done_d    = (state_d == ST_DONE);
    end

    // State and status registers; reset abandons any transfer silently
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            dir_q     <= 1'b0;
            sl_q      <= 9'd0;
            drq_q     <= 1'b0;
            hps_req_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            flush_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            sl_q      <= sl_d;
            drq_q     <= drq_d;
            hps_req_q <= hps_req_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            flush_q   <= flush_d;
        end
    end

    assign drq          = drq_q;
    assign hps_req      = hps_req_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign fifo_flush   = flush_q;
    assign sectors_left = sl_q;

`ifdef GAYLE_XFER_IRQ_EN
    logic irq_q, irq_d;

    // Interrupt on every fresh entry into CPU_XFER and on entry into DONE
    always_comb begin
        irq_d = ((state_d == ST_CPU_XFER) && (state_q != ST_CPU_XFER)) ||
                ((state_d == ST_DONE) && (state_q != ST_DONE));
    end

    // Interrupt pulse register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_gayle_xfer_ctrl.sv
// Self-checking bench for gayle_xfer_ctrl: vector table, directed sequences and randomized traffic
// against a phase-counting reference model. A second instance with 2-word sectors runs the
// 256-sector (count=0) transfer in a practical number of cycles.
module tb_gayle_xfer_ctrl;

    localparam int SW = 256;
`ifdef GAYLE_XFER_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       i_c7, i_start, i_dir, i_abort, i_crd, i_cwr, i_hrd, i_hwr;
    logic [7:0] i_count;

    logic       fifo_rd, fifo_wr, fifo_fast_rd, fifo_fast_wr, fifo_flush;
    logic       drq, hps_req, busy, done, irq;
    logic [8:0] sectors_left;

    logic       s_rd, s_wr, s_frd, s_fwr, s_flush, s_drq, s_hreq, s_busy, s_done, s_irq;
    logic [8:0] s_sl;

    always #5 clk = ~clk;

    gayle_xfer_ctrl #(.SECTOR_WORDS(SW)) u_dut (
        .clk(clk), .reset(reset), .clk7_en(i_c7), .cmd_start(i_start), .cmd_dir(i_dir),
        .cmd_count(i_count), .abort(i_abort), .cpu_rd(i_crd), .cpu_wr(i_cwr),
        .hps_rd(i_hrd), .hps_wr(i_hwr), .fifo_rd(fifo_rd), .fifo_wr(fifo_wr),
        .fifo_fast_rd(fifo_fast_rd), .fifo_fast_wr(fifo_fast_wr), .fifo_flush(fifo_flush),
        .drq(drq), .hps_req(hps_req), .busy(busy), .done(done), .irq(irq),
        .sectors_left(sectors_left)
    );

    gayle_xfer_ctrl #(.SECTOR_WORDS(2)) u_small (
        .clk(clk), .reset(reset), .clk7_en(i_c7), .cmd_start(i_start), .cmd_dir(i_dir),
        .cmd_count(i_count), .abort(i_abort), .cpu_rd(i_crd), .cpu_wr(i_cwr),
        .hps_rd(i_hrd), .hps_wr(i_hwr), .fifo_rd(s_rd), .fifo_wr(s_wr),
        .fifo_fast_rd(s_frd), .fifo_fast_wr(s_fwr), .fifo_flush(s_flush),
        .drq(s_drq), .hps_req(s_hreq), .busy(s_busy), .done(s_done), .irq(s_irq),
        .sectors_left(s_sl)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    // Reference model: a transfer is 2*N alternating phases of SW words each.
    // dir=1 phases go HPS,CPU,HPS,...; dir=0 phases go CPU,HPS,CPU,...
    int m_act, m_dir, m_nsec, m_phase, m_words, m_indone, m_sl;
    int e_flush, e_done, e_irq;

    function automatic int owner_cpu();
        if (m_act == 0 || m_indone != 0) return 0;
        return ((m_phase % 2) == 0) ? int'(m_dir == 0) : int'(m_dir == 1);
    endfunction
    function automatic int owner_hps();
        if (m_act == 0 || m_indone != 0) return 0;
        return 1 - owner_cpu();
    endfunction

    task automatic model_reset();
        m_act = 0; m_dir = 0; m_nsec = 0; m_phase = 0; m_words = 0; m_indone = 0; m_sl = 0;
        e_flush = 0; e_done = 0; e_irq = 0;
    endtask

    // Observed-event counters, cleared by each scenario
    int n_rd, n_wr, n_frd, n_fwr, n_done, n_irq, n_flush, n_sdone;
    logic [3:0] last_strb;
    task automatic clr_counts();
        n_rd = 0; n_wr = 0; n_frd = 0; n_fwr = 0; n_done = 0; n_irq = 0; n_flush = 0; n_sdone = 0;
    endtask

    // One clock: called just after a rising edge with inputs already applied
    task automatic cyc();
        int oc, oh, x_rd, x_wr, x_frd, x_fwr, beat;
        @(negedge clk);
        oc = owner_cpu(); oh = owner_hps();
        x_rd  = int'(!i_abort && oc != 0 && i_c7 && m_dir == 1 && i_crd);
        x_wr  = int'(!i_abort && oc != 0 && i_c7 && m_dir == 0 && i_cwr);
        x_fwr = int'(!i_abort && oh != 0 && m_dir == 1 && i_hwr);
        x_frd = int'(!i_abort && oh != 0 && m_dir == 0 && i_hrd);
        chk("fifo_rd", int'(fifo_rd), x_rd);
        chk("fifo_wr", int'(fifo_wr), x_wr);
        chk("fifo_fast_rd", int'(fifo_fast_rd), x_frd);
        chk("fifo_fast_wr", int'(fifo_fast_wr), x_fwr);
        last_strb = {fifo_rd, fifo_wr, fifo_fast_rd, fifo_fast_wr};
        n_rd += int'(fifo_rd); n_wr += int'(fifo_wr);
        n_frd += int'(fifo_fast_rd); n_fwr += int'(fifo_fast_wr);
        beat = x_rd + x_wr + x_frd + x_fwr;
        e_flush = int'(i_abort); e_done = 0; e_irq = 0;
        if (i_abort) begin
            m_act = 0; m_indone = 0; m_sl = 0;
        end else if (m_act == 0) begin
            if (i_start) begin
                m_act = 1; m_dir = int'(i_dir); m_nsec = (i_count == 0) ? 256 : int'(i_count);
                m_phase = 0; m_words = 0; m_sl = m_nsec;
                e_irq = int'(i_dir == 1'b0);
            end
        end else if (m_indone != 0) begin
            m_act = 0; m_indone = 0;
        end else if (beat != 0) begin
            m_words++;
            if (m_words == SW) begin
                m_words = 0;
                m_phase++;
                if (m_phase == 2 * m_nsec) begin
                    m_indone = 1; e_done = 1; e_irq = 1;
                end else begin
                    m_sl = m_nsec - m_phase / 2;
                    e_irq = owner_cpu();
                end
            end
        end
        @(posedge clk);
        #1;
        chk("drq", int'(drq), owner_cpu());
        chk("hps_req", int'(hps_req), owner_hps());
        chk("busy", int'(busy), m_act);
        chk("done", int'(done), e_done);
        chk("fifo_flush", int'(fifo_flush), e_flush);
        chk("irq", int'(irq), IRQ_ON ? e_irq : 0);
        chk("sectors_left", int'(sectors_left), m_sl);
        n_done += int'(done); n_irq += int'(irq); n_flush += int'(fifo_flush);
        n_sdone += int'(s_done);
    endtask

    task automatic idle_in();
        i_c7 = 1'b0; i_start = 1'b0; i_dir = 1'b0; i_count = 8'd0; i_abort = 1'b0;
        i_crd = 1'b0; i_cwr = 1'b0; i_hrd = 1'b0; i_hwr = 1'b0;
    endtask

    task automatic start_cmd(input logic dir, input logic [7:0] cnt);
        idle_in(); i_start = 1'b1; i_dir = dir; i_count = cnt; cyc(); idle_in();
    endtask

    task automatic do_abort();
        idle_in(); i_abort = 1'b1; cyc(); idle_in();
    endtask

    // Move n words on one side; cpu side uses clk7_en
    task automatic beats(input bit cpu_side, input logic dir, input int n);
        for (int k = 0; k < n; k++) begin
            idle_in();
            if (cpu_side) begin i_c7 = 1'b1; i_crd = dir; i_cwr = ~dir; end
            else          begin i_hwr = dir; i_hrd = ~dir; end
            cyc();
        end
        idle_in();
    endtask

    typedef struct {
        logic       st, dr;
        logic [7:0] cnt;
        logic       ab, c7, crd, cwr, hrd, hwr;
        logic [3:0] e_strb;   // {rd, wr, fast_rd, fast_wr}
        logic       e_drq, e_hreq, e_busy, e_flush;
    } vec_t;

    vec_t vt[15];

    initial begin
        // st dr cnt  ab c7 crd cwr hrd hwr  strb    drq hreq busy flush
        vt[0]  = '{1, 0, 8'd2, 0, 0, 0, 0, 0, 0, 4'b0000, 1, 0, 1, 0};
        vt[1]  = '{0, 0, 8'd0, 0, 0, 0, 1, 0, 0, 4'b0000, 1, 0, 1, 0};
        vt[2]  = '{0, 0, 8'd0, 0, 1, 0, 1, 0, 0, 4'b0100, 1, 0, 1, 0};
        vt[3]  = '{0, 0, 8'd0, 0, 1, 1, 0, 0, 0, 4'b0000, 1, 0, 1, 0};
        vt[4]  = '{0, 0, 8'd0, 0, 0, 0, 0, 1, 1, 4'b0000, 1, 0, 1, 0};
        vt[5]  = '{1, 1, 8'd1, 0, 1, 0, 1, 0, 0, 4'b0100, 1, 0, 1, 0};
        vt[6]  = '{0, 0, 8'd0, 1, 1, 0, 1, 0, 0, 4'b0000, 0, 0, 0, 1};
        vt[7]  = '{0, 0, 8'd0, 0, 1, 1, 1, 1, 1, 4'b0000, 0, 0, 0, 0};
        vt[8]  = '{1, 1, 8'd1, 1, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 1};
        vt[9]  = '{0, 0, 8'd0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0};
        vt[10] = '{1, 1, 8'd1, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 1, 1, 0};
        vt[11] = '{0, 0, 8'd0, 0, 0, 0, 0, 0, 1, 4'b0001, 0, 1, 1, 0};
        vt[12] = '{0, 0, 8'd0, 0, 0, 0, 0, 1, 0, 4'b0000, 0, 1, 1, 0};
        vt[13] = '{0, 0, 8'd0, 0, 1, 1, 0, 0, 0, 4'b0000, 0, 1, 1, 0};
        vt[14] = '{0, 0, 8'd0, 1, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 1};

        // ---- reset: outputs low even with strobes and start asserted
        model_reset(); clr_counts();
        idle_in();
        reset = 1'b1; i_c7 = 1'b1; i_crd = 1'b1; i_cwr = 1'b1; i_hrd = 1'b1; i_hwr = 1'b1; i_start = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_strobes", int'({fifo_rd, fifo_wr, fifo_fast_rd, fifo_fast_wr}), 0);
        chk("rst_status", int'({drq, hps_req, busy, done, fifo_flush, irq}), 0);
        chk("rst_sectors_left", int'(sectors_left), 0);
        reset = 1'b0; idle_in();
        @(posedge clk); #1;
        chk("post_rst_busy", int'(busy), 0);

        // ---- vector table
        for (int v = 0; v < 15; v++) begin
            i_start = vt[v].st; i_dir = vt[v].dr; i_count = vt[v].cnt; i_abort = vt[v].ab;
            i_c7 = vt[v].c7; i_crd = vt[v].crd; i_cwr = vt[v].cwr; i_hrd = vt[v].hrd; i_hwr = vt[v].hwr;
            cyc();
            chk($sformatf("vec%0d_strb", v), int'(last_strb), int'(vt[v].e_strb));
            chk($sformatf("vec%0d_stat", v), int'({drq, hps_req, busy, fifo_flush}),
                int'({vt[v].e_drq, vt[v].e_hreq, vt[v].e_busy, vt[v].e_flush}));
        end
        idle_in(); cyc();

        // ---- read, one sector
        clr_counts();
        start_cmd(1'b1, 8'd1);
        chk("rd1_hps_req", int'(hps_req), 1);
        beats(1'b0, 1'b1, SW);
        chk("rd1_fast_wr_total", n_fwr, SW);
        chk("rd1_drq_after_fill", int'(drq), 1);
        beats(1'b1, 1'b1, SW);
        chk("rd1_done_pulse", int'(done), 1);
        idle_in(); cyc();
        chk("rd1_busy_end", int'(busy), 0);
        chk("rd1_done_count", n_done, 1);
        chk("rd1_fifo_rd_total", n_rd, SW);

        // ---- write, two sectors
        clr_counts();
        start_cmd(1'b0, 8'd2);
        chk("wr2_drq_first", int'(drq), 1);
        for (int s = 0; s < 2; s++) begin
            beats(1'b1, 1'b0, SW);
            chk($sformatf("wr2_s%0d_hps_req", s), int'(hps_req), 1);
            beats(1'b0, 1'b0, SW);
            if (s == 0) chk("wr2_sectors_left_dec", int'(sectors_left), 1);
        end
        chk("wr2_done_pulse", int'(done), 1);
        idle_in(); cyc();
        chk("wr2_fifo_wr_total", n_wr, 2 * SW);
        chk("wr2_fast_rd_total", n_frd, 2 * SW);
        chk("wr2_done_count", n_done, 1);

        // ---- read, two sectors: irq count, with idle clk7 gaps on the CPU side
        clr_counts();
        start_cmd(1'b1, 8'd2);
        for (int s = 0; s < 2; s++) begin
            beats(1'b0, 1'b1, SW);
            for (int k = 0; k < SW; k++) begin
                idle_in(); i_crd = 1'b1; i_c7 = (k % 3 != 2); cyc();
                if (k % 3 == 2) begin i_c7 = 1'b1; cyc(); end
            end
        end
        idle_in(); cyc();
        chk("rd2_irq_pulses", n_irq, IRQ_ON ? 3 : 0);
        chk("rd2_done_count", n_done, 1);

        // ---- abort after 100 words in CPU_XFER
        clr_counts();
        start_cmd(1'b0, 8'd3);
        beats(1'b1, 1'b0, 100);
        do_abort();
        chk("abort_flush", int'(fifo_flush), 1);
        chk("abort_idle", int'(busy), 0);
        idle_in(); i_c7 = 1'b1; i_crd = 1'b1; i_cwr = 1'b1; cyc();
        chk("abort_flush_one_cycle", int'(fifo_flush), 0);
        chk("abort_no_cpu_strobe", n_rd + n_wr - 100, 0);
        chk("abort_no_done", n_done, 0);
        idle_in();

        // ---- reset in mid-transfer: no done, no flush
        start_cmd(1'b1, 8'd1);
        beats(1'b0, 1'b1, 10);
        i_hwr = 1'b1;
        #2 reset = 1'b1;
        #1;
        chk("midrst_status", int'({busy, hps_req, done, fifo_flush}), 0);
        @(negedge clk);
        chk("midrst_strobe", int'(fifo_fast_wr), 0);
        reset = 1'b0; idle_in(); model_reset();
        @(posedge clk); #1;
        chk("midrst_after", int'({busy, done, fifo_flush}), 0);
        chk("midrst_sl", int'(sectors_left), 0);

        // ---- randomized traffic against the model
        for (int c = 0; c < 6000; c++) begin
            idle_in();
            i_c7 = ($urandom_range(0, 9) < 7);
            i_crd = $urandom_range(0, 9) < 6; i_cwr = $urandom_range(0, 9) < 6;
            i_hrd = $urandom_range(0, 9) < 6; i_hwr = $urandom_range(0, 9) < 6;
            i_start = ($urandom_range(0, 7) == 0);
            i_dir = 1'($urandom_range(0, 1));
            i_count = 8'($urandom_range(1, 2));
            i_abort = ($urandom_range(0, 1499) == 0);
            cyc();
        end
        idle_in();
        do_abort();

        // ---- count=0 on the 2-word instance: 256 sectors before done
        clr_counts();
        start_cmd(1'b1, 8'd0);
        chk("cnt0_sectors_left_256", int'(s_sl), 256);
        chk("cnt0_big_sectors_left_256", int'(sectors_left), 256);
        for (int s = 0; s < 256; s++) begin
            beats(1'b0, 1'b1, 2);
            if (s < 255) beats(1'b1, 1'b1, 2);
            else         beats(1'b1, 1'b1, 1);
            if (s == 0)   chk("cnt0_sl_after_first", int'(s_sl), 255);
            if (s == 254) chk("cnt0_sl_last", int'(s_sl), 1);
        end
        chk("cnt0_no_early_done", n_sdone, 0);
        beats(1'b1, 1'b1, 1);
        chk("cnt0_done", int'(s_done), 1);
        idle_in(); cyc();
        chk("cnt0_busy_end", int'(s_busy), 0);
        chk("cnt0_done_count", n_sdone, 1);
        do_abort();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
